// File: rtl/cmp_pkg.sv
// ---------------------------------------------------------------------------
// | Package : cmp_pkg                                                       |
// | Shared types for the serial magnitude comparator.                       |
// | Revision: 1.0 - initial release                                         |
// ---------------------------------------------------------------------------
`default_nettype none

package cmp_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

`default_nettype wire

// File: rtl/twobit_compare_slice.sv
// ---------------------------------------------------------------------------
// | Module  : twobit_compare_slice                                          |
// | Combinational 2-bit unsigned compare producing gt and eq.               |
// | Revision: 1.0 - initial release                                         |
// ---------------------------------------------------------------------------
`default_nettype none

module twobit_compare_slice (
  input  logic [1:0] a,
  input  logic [1:0] b,
  output logic       gt,
  output logic       eq
);

  assign gt = (a > b);
  assign eq = (a == b);

endmodule

`default_nettype wire

// File: rtl/serial_greater_than.sv
// ---------------------------------------------------------------------------
// | Module  : serial_greater_than                                           |
// | Multi-cycle W-bit unsigned comparator, two bits per clock, MSB first.   |
// | Option  : SERIAL_GT_EARLY_EXIT_EN - finish at the first differing slice |
// | Revision: 1.0 - initial release                                         |
// ---------------------------------------------------------------------------
`default_nettype none

module serial_greater_than
  import cmp_pkg::*;
#(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic         ready,
  output logic         done,
  output logic         agtb,
  output logic         aeqb
);

  localparam int NS = W / 2;
  localparam int IW = (NS > 1) ? $clog2(NS) : 1;
  localparam logic [IW-1:0] c_last_idx = IW'(NS - 1);

  if ((W < 2) || ((W % 2) != 0)) begin : g_bad_width
    $fatal(1, "serial_greater_than: W must be even and >= 2");
  end

  state_t        r_state;
  state_t        w_next;
  logic [W-1:0]  r_a;
  logic [W-1:0]  r_b;
  logic [IW-1:0] r_idx;
  logic          r_decided;
  logic          r_gt_flag;
  logic          r_agtb;
  logic          r_aeqb;

  logic [1:0]    w_sa;
  logic [1:0]    w_sb;
  logic          w_gt;
  logic          w_eq;
  logic          w_dec_final;
  logic          w_gt_final;

  // Current slice is selected by shifting it down to bit 0.
  assign w_sa = 2'(r_a >> {r_idx, 1'b0});
  assign w_sb = 2'(r_b >> {r_idx, 1'b0});

  twobit_compare_slice u_slice (
    .a  (w_sa),
    .b  (w_sb),
    .gt (w_gt),
    .eq (w_eq)
  );

  // Decision including the slice examined this cycle; first difference wins.
  assign w_dec_final = r_decided | ~w_eq;
  assign w_gt_final  = r_decided ? r_gt_flag : w_gt;

  always_ff @(posedge clk) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE: if (start) w_next = RUN;
      RUN: begin
`ifdef SERIAL_GT_EARLY_EXIT_EN
        if (!w_eq || (r_idx == '0)) w_next = DONE;
`else
        if (r_idx == '0) w_next = DONE;
`endif
      end
      DONE:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_comb begin
    ready = (r_state == IDLE);
    done  = (r_state == DONE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_a       <= '0;
      r_b       <= '0;
      r_idx     <= c_last_idx;
      r_decided <= 1'b0;
      r_gt_flag <= 1'b0;
      r_agtb    <= 1'b0;
      r_aeqb    <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (start) begin
            r_a       <= a;
            r_b       <= b;
            r_idx     <= c_last_idx;
            r_decided <= 1'b0;
            r_gt_flag <= 1'b0;
          end
        end
        RUN: begin
          r_decided <= w_dec_final;
          r_gt_flag <= w_gt_final;
          if (r_idx != '0) r_idx <= r_idx - 1'b1;
          if (w_next == DONE) begin
            r_agtb <= w_gt_final;
            r_aeqb <= ~w_dec_final;
          end
        end
        default: ;
      endcase
    end
  end

  assign agtb = r_agtb;
  assign aeqb = r_aeqb;

endmodule

`default_nettype wire

// File: tb/tb_serial_greater_than.sv
// ---------------------------------------------------------------------------
// | Module  : tb_serial_greater_than                                        |
// | Self-checking bench for serial_greater_than (W=8 and W=2 instances).    |
// | Revision: 1.0 - initial release                                         |
// ---------------------------------------------------------------------------
`default_nettype none

module tb_serial_greater_than;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       gt;
    logic       eq;
  } vec_t;

  typedef struct {
    logic gt;
    logic eq;
    int   lat;
  } exp_t;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       start8 = 1'b0;
  logic [7:0] a8 = '0;
  logic [7:0] b8 = '0;
  logic       ready8, done8, agtb8, aeqb8;
  logic       start2 = 1'b0;
  logic [1:0] a2 = '0;
  logic [1:0] b2 = '0;
  logic       ready2, done2, agtb2, aeqb2;

  int   n_tests = 0;
  int   n_fail  = 0;
  exp_t sbq[$];
  vec_t vecs[9];

  always #5 clk = ~clk;

  serial_greater_than #(.W(8)) dut8 (
    .clk(clk), .reset(reset), .start(start8), .a(a8), .b(b8),
    .ready(ready8), .done(done8), .agtb(agtb8), .aeqb(aeqb8)
  );

  serial_greater_than #(.W(2)) dut2 (
    .clk(clk), .reset(reset), .start(start2), .a(a2), .b(b2),
    .ready(ready2), .done(done2), .agtb(agtb2), .aeqb(aeqb2)
  );

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  // Cycles from acceptance edge to the edge that raises done.
  function automatic int exp_lat(input logic [7:0] ta, input logic [7:0] tb, input int ns);
`ifdef SERIAL_GT_EARLY_EXIT_EN
    for (int s = ns - 1; s >= 0; s--)
      if (ta[2*s +: 2] != tb[2*s +: 2]) return ns - s;
`endif
    return ns;
  endfunction

  task automatic cmp8(input logic [7:0] ta, input logic [7:0] tb, input logic egt,
                      input logic eeq, input string nm);
    exp_t e;
    int   k;
    k = 0;
    while (!ready8 && k < 50) begin @(negedge clk); k++; end
    check({nm, "_ready_in"}, ready8, 1);
    a8 = ta; b8 = tb; start8 = 1'b1;
    e.gt = egt; e.eq = eeq; e.lat = exp_lat(ta, tb, 4);
    sbq.push_back(e);
    @(posedge clk);
    @(negedge clk);
    start8 = 1'b0;
    k = 0;
    while (!done8 && k < 40) begin @(posedge clk); @(negedge clk); k++; end
    e = sbq.pop_front();
    check({nm, "_done_seen"}, done8, 1);
    check({nm, "_agtb"}, agtb8, e.gt);
    check({nm, "_aeqb"}, aeqb8, e.eq);
    check({nm, "_latency"}, k, e.lat);
    @(posedge clk);
    @(negedge clk);
    check({nm, "_done_drop"}, done8, 0);
    check({nm, "_ready_back"}, ready8, 1);
  endtask

  task automatic cmp2(input logic [1:0] ta, input logic [1:0] tb);
    exp_t e;
    int   k;
    string nm;
    nm = $sformatf("w2_%0d_%0d", ta, tb);
    a2 = ta; b2 = tb; start2 = 1'b1;
    e.gt = (ta > tb); e.eq = (ta == tb); e.lat = 1;
    sbq.push_back(e);
    @(posedge clk);
    @(negedge clk);
    start2 = 1'b0;
    check({nm, "_busy"}, ready2, 0);
    k = 0;
    while (!done2 && k < 10) begin @(posedge clk); @(negedge clk); k++; end
    e = sbq.pop_front();
    check({nm, "_agtb"}, agtb2, e.gt);
    check({nm, "_aeqb"}, aeqb2, e.eq);
    check({nm, "_latency"}, k, e.lat);
    @(posedge clk);
    @(negedge clk);
    check({nm, "_ready_back"}, ready2, 1);
  endtask

  initial begin
    int         pulses;
    int         k;
    logic [3:0] v;
    exp_t       e;

    vecs[0] = '{8'hA5, 8'h5A, 1'b1, 1'b0};
    vecs[1] = '{8'h3C, 8'h3C, 1'b0, 1'b1};
    vecs[2] = '{8'h12, 8'h13, 1'b0, 1'b0};
    vecs[3] = '{8'h80, 8'h7F, 1'b1, 1'b0};
    vecs[4] = '{8'h00, 8'hFF, 1'b0, 1'b0};
    vecs[5] = '{8'hFF, 8'hFE, 1'b1, 1'b0};
    vecs[6] = '{8'hFF, 8'hFF, 1'b0, 1'b1};
    vecs[7] = '{8'h7F, 8'h80, 1'b0, 1'b0};
    vecs[8] = '{8'h00, 8'h00, 1'b0, 1'b1};

    repeat (3) @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("idle_ready", ready8, 1);
      check("idle_done", done8, 0);
      check("idle_agtb", agtb8, 0);
      check("idle_aeqb", aeqb8, 0);
    end
    check("idle_ready_w2", ready2, 1);
    check("idle_agtb_w2", agtb2, 0);

    for (int i = 0; i < 9; i++)
      cmp8(vecs[i].a, vecs[i].b, vecs[i].gt, vecs[i].eq, $sformatf("vec%0d", i));

    // start held through RUN with operand A changing after acceptance
    a8 = 8'h01; b8 = 8'hFF; start8 = 1'b1;
    e.gt = 1'b0; e.eq = 1'b0; e.lat = exp_lat(8'h01, 8'hFF, 4);
    sbq.push_back(e);
    @(posedge clk);
    @(negedge clk);
    a8 = 8'hFF;
    k = 0;
    while (!done8 && k < 40) begin @(posedge clk); @(negedge clk); k++; end
    start8 = 1'b0;
    pulses = done8 ? 1 : 0;
    e = sbq.pop_front();
    check("hold_agtb", agtb8, e.gt);
    check("hold_aeqb", aeqb8, e.eq);
    check("hold_latency", k, e.lat);
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      @(negedge clk);
      if (done8) pulses++;
    end
    check("hold_done_pulses", pulses, 1);

    // reset in the middle of RUN discards the compare
    cmp8(8'hFF, 8'h00, 1'b1, 1'b0, "pre_reset");
    a8 = 8'h01; b8 = 8'h00; start8 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start8 = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("midrun_busy", ready8, 0);
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    check("rst_ready", ready8, 1);
    check("rst_done", done8, 0);
    check("rst_agtb", agtb8, 0);
    check("rst_aeqb", aeqb8, 0);
    pulses = 0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk);
      @(negedge clk);
      if (done8) pulses++;
    end
    check("rst_no_done", pulses, 0);
    cmp8(8'h80, 8'h7F, 1'b1, 1'b0, "post_reset");

    for (int i = 0; i < 16; i++) begin
      v = i[3:0];
      cmp2(v[3:2], v[1:0]);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule

`default_nettype wire
